// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to instruction
// memory and hands each fetched word with its PC to decode over valid/ready.
module ysyx_22050612_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [63:0]      imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst,
   output logic [63:0]      inst_pc,
   input  logic             redirect_valid,
   input  logic [63:0]      redirect_pc,
   input  logic             halt,
   output logic             halted,
   output logic             misalign_err,
   output logic [CNT_W-1:0] inst_cnt
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

   state_t           r_state, w_state_nxt;
   logic [63:0]      r_pc;
   logic             r_drop;
   logic [31:0]      r_inst;
   logic [63:0]      r_inst_pc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_misalign;

   logic [63:0] w_target;
   logic        w_redir;
   logic        w_req_fire;
   logic        w_rsp_wait;
   logic        w_inst_fire;
   logic        w_latch;

   assign w_target    = {redirect_pc[63:2], 2'b00};
   // halt wins over everything, so a redirect that arrives with it has no effect
   assign w_redir     = redirect_valid && (r_state != S_HALT) && !halt;
   assign w_req_fire  = (r_state == S_REQ) && imem_req_ready;
   assign w_rsp_wait  = (r_state == S_WAIT) && imem_rsp_valid;
   assign w_inst_fire = (r_state == S_HOLD) && inst_ready;
   assign w_latch     = w_rsp_wait && !r_drop && !w_redir && !halt;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_REQ;
      else        r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (halt || r_state == S_HALT) begin
         w_state_nxt = S_HALT;
      end else begin
         case (r_state)
            S_REQ:  if (imem_req_ready) w_state_nxt = S_WAIT;
            S_WAIT: if (imem_rsp_valid) w_state_nxt = (r_drop || w_redir) ? S_REQ : S_HOLD;
            S_HOLD: if (inst_ready || w_redir) w_state_nxt = S_REQ;
            default: w_state_nxt = S_HALT;
         endcase
      end
   end

   // outputs
   always_comb begin
      imem_req_valid = (r_state == S_REQ);
      inst_valid     = (r_state == S_HOLD);
      halted         = (r_state == S_HALT);
   end

   assign imem_addr    = r_pc;
   assign inst         = r_inst;
   assign inst_pc      = r_inst_pc;
   assign inst_cnt     = r_cnt;
   assign misalign_err = r_misalign;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_drop     <= 1'b0;
         r_inst     <= 32'h0;
         r_inst_pc  <= 64'h0;
         r_cnt      <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_redir && (redirect_pc[1:0] != 2'b00);
         if (w_redir)                  r_pc <= w_target;
         else if (w_inst_fire && !halt) r_pc <= r_pc + 64'd4;
         // a fetch in flight when the PC changes must have its word thrown away
         if (w_rsp_wait)                                  r_drop <= 1'b0;
         else if (w_redir && (w_req_fire || r_state == S_WAIT)) r_drop <= 1'b1;
         if (w_latch) begin
            r_inst    <= imem_rsp_data;
            r_inst_pc <= r_pc;
         end
         if (w_inst_fire) r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed bench for the fetch unit: sequential fetch, decode back-pressure,
// redirects in each state, misaligned target, halt and restart from reset.
module tb_ysyx_22050612_ifu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt, halted, misalign_err;
   logic [31:0] inst_cnt;

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   ysyx_22050612_ifu dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .halted(halted), .misalign_err(misalign_err),
      .inst_cnt(inst_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return a[31:0] ^ 32'hA5A5_0F0F;
   endfunction

   // REQ at addr -> WAIT -> HOLD with the word for that address
   task automatic fetch(input logic [63:0] addr);
      chk("req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("req_addr", imem_addr, addr);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk("wait_noreq", {63'd0, imem_req_valid}, 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(addr);
      step();
      imem_rsp_valid = 1'b0;
      chk("hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("inst", {32'd0, inst}, {32'd0, word_of(addr)});
      chk("inst_pc", inst_pc, addr);
   endtask

   task automatic consume(input logic [31:0] exp_cnt);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("inst_cnt", {32'd0, inst_cnt}, {32'd0, exp_cnt});
   endtask

   initial begin
      rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; halt = 1'b0;
      step(); step();
      chk("rst_addr", imem_addr, 64'h8000_0000);
      chk("rst_cnt", {32'd0, inst_cnt}, 64'd0);
      chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_inst", {32'd0, inst}, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
      rst_n = 1'b1;

      // sequential fetch
      fetch(64'h8000_0000); consume(1);
      fetch(64'h8000_0004); consume(2);
      fetch(64'h8000_0008); consume(3);

      // decode back-pressure
      fetch(64'h8000_000C);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_inst", {32'd0, inst}, {32'd0, word_of(64'h8000_000C)});
         chk("bp_inst_pc", inst_pc, 64'h8000_000C);
         chk("bp_noreq", {63'd0, imem_req_valid}, 64'd0);
         chk("bp_cnt", {32'd0, inst_cnt}, 64'd3);
      end
      consume(4);

      // redirect while waiting for the response
      chk("pre_wait_addr", imem_addr, 64'h8000_0010);
      imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; step(); redirect_valid = 1'b0;
      chk("rw_still_wait", {63'd0, imem_req_valid | inst_valid}, 64'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; step(); imem_rsp_valid = 1'b0;
      chk("rw_dropped", {63'd0, inst_valid}, 64'd0);
      fetch(64'h8000_0100); consume(5);

      // redirect in HOLD with consume
      fetch(64'h8000_0104);
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0040; step();
      inst_ready = 1'b0; redirect_valid = 1'b0;
      chk("rh_cnt", {32'd0, inst_cnt}, 64'd6);
      chk("rh_misalign", {63'd0, misalign_err}, 64'd0);

      // redirect in HOLD without consume: flushed, not counted
      fetch(64'h8000_0040);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0040; step(); redirect_valid = 1'b0;
      chk("rf_cnt", {32'd0, inst_cnt}, 64'd6);
      chk("rf_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rf_addr", imem_addr, 64'h8000_0040);

      // misaligned redirect while REQ is stalled
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0042; step(); redirect_valid = 1'b0;
      chk("mis_pulse", {63'd0, misalign_err}, 64'd1);
      chk("mis_addr", imem_addr, 64'h8000_0040);
      step();
      chk("mis_clear", {63'd0, misalign_err}, 64'd0);

      // redirect on the cycle the request is accepted
      imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; step();
      imem_req_ready = 1'b0; redirect_valid = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678; step(); imem_rsp_valid = 1'b0;
      chk("rr_dropped", {63'd0, inst_valid}, 64'd0);
      chk("rr_addr", imem_addr, 64'h8000_0200);

      // halt during WAIT
      imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
      halt = 1'b1; step(); halt = 1'b0;
      chk("halted", {63'd0, halted}, 64'd1);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D; step(); imem_rsp_valid = 1'b0;
      chk("halt_rsp_ignored", {63'd0, inst_valid}, 64'd0);
      imem_req_ready = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("halt_noreq", {63'd0, imem_req_valid | inst_valid}, 64'd0);
      end
      imem_req_ready = 1'b0; inst_ready = 1'b0;
      chk("halt_cnt", {32'd0, inst_cnt}, 64'd6);
      chk("halt_stays", {63'd0, halted}, 64'd1);

      // restart
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("rs_halted", {63'd0, halted}, 64'd0);
      chk("rs_cnt", {32'd0, inst_cnt}, 64'd0);
      fetch(64'h8000_0000); consume(1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
